// File: rtl/spi_txn_arbiter_if.sv
// Bus bundle between requesters, the transaction arbiter and the SPI byte engine.
// The master modport is the arbiter; the slave modport is the requesters plus the engine.
interface spi_txn_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LEN_W = 4
);
    // requester side
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ*8-1:0]     tx_data;
    logic [NREQ-1:0]       grant;
    logic                  tx_ack;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  txn_done;
    logic                  busy;
    logic [NREQ-1:0]       cs_n;

    // byte engine side
    logic                  eng_start;
    logic [7:0]            eng_data_in;
    logic                  eng_done;
    logic [7:0]            eng_data_out;

    modport master (
        input  req, req_len, tx_data, eng_done, eng_data_out,
        output grant, tx_ack, rx_data, rx_valid, txn_done, busy, cs_n,
        output eng_start, eng_data_in
    );

    modport slave (
        output req, req_len, tx_data, eng_done, eng_data_out,
        input  grant, tx_ack, rx_data, rx_valid, txn_done, busy, cs_n,
        input  eng_start, eng_data_in
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin SPI transaction arbiter: shares one byte engine among NREQ requesters,
// holding the winner's chip select low for its whole multi-byte transaction.
module spi_txn_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    spi_txn_arbiter_if.master   bus
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StIssue,
        StWait,
        StHold
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] win_q;
    logic [LEN_W-1:0] remaining_q;
    logic [NREQ-1:0]  grant_q;
    logic [NREQ-1:0]  cs_n_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [LEN_W-1:0] pick_len;
    logic [IDX_W-1:0] ptr_next;

    // First requesting index in the order ptr, ptr+1, ... wrapping at NREQ-1.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand     = (32'(ptr_q) + k) % NREQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && bus.req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        pick_len = bus.req_len[32'(pick_idx) * LEN_W +: LEN_W];
        if (win_q == IDX_W'(NREQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            win_q       <= '0;
            remaining_q <= '0;
            grant_q     <= '0;
            cs_n_q      <= '1;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        win_q       <= pick_idx;
                        grant_q     <= ONE_HOT0 << pick_idx;
                        cs_n_q      <= ~(ONE_HOT0 << pick_idx);
                        // A zero length still moves one byte.
                        remaining_q <= (pick_len == '0) ? LEN_W'(1) : pick_len;
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    state_q <= StIssue;
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (bus.eng_done) begin
                        rx_data_q   <= bus.eng_data_out;
                        rx_valid_q  <= 1'b1;
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            cs_n_q  <= '1;
                            state_q <= StHold;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StHold: begin
                    ptr_q   <= ptr_next;
                    grant_q <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    grant_q <= '0;
                    cs_n_q  <= '1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Per-state strobes are plain state decodes so they last exactly one cycle.
    assign bus.eng_start   = (state_q == StIssue);
    assign bus.tx_ack      = (state_q == StIssue);
    assign bus.eng_data_in = (state_q == StIssue) ? bus.tx_data[32'(win_q) * 8 +: 8] : 8'h00;
    assign bus.txn_done    = (state_q == StHold);
    assign bus.busy        = (state_q != StIdle);
    assign bus.grant       = grant_q;
    assign bus.cs_n        = cs_n_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Transaction-level controller that shares one SPI byte engine between NREQ requesters. It arbitrates round-robin, holds the winner's chip select low across a multi-byte transaction, and issues one engine start per byte. It returns each received byte to the winner and releases chip select at the end. It sits between the per-device client logic and the SPI byte engine (start / data_in / done / data_out contract).

## Interface
- NREQ, 4: number of requesters and chip selects (2..8).
- LEN_W, 4: width of per-request byte count; max transaction length is 2^LEN_W-1 bytes.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester transaction request; level, held until txn_done for that requester.
- req_len  in  NREQ*LEN_W  byte count per requester, slice i = [i*LEN_W +: LEN_W]; sampled at grant.
- tx_data  in  NREQ*8  next transmit byte per requester, slice i = [i*8 +: 8]; read at tx_ack.
- grant  out  NREQ  one-hot owner of the engine; all zero when idle.
- tx_ack  out  1  one-cycle pulse; granted requester's tx_data consumed this cycle, present next byte from next cycle.
- rx_data  out  8  last byte received from the engine.
- rx_valid  out  1  one-cycle pulse, rx_data valid for granted requester.
- txn_done  out  1  one-cycle pulse, transaction of granted requester complete; grant still valid this cycle.
- busy  out  1  high in every state except IDLE.
- cs_n  out  NREQ  active-low device selects; only cs_n[grant index] may be low.
- eng_start  out  1  byte engine start pulse.
- eng_data_in  out  8  byte to engine, valid with eng_start.
- eng_done  in  1  engine one-cycle completion pulse.
- eng_data_out  in  8  engine received byte, valid with eng_done.

## Operation
- States: IDLE, SETUP, ISSUE, WAIT, HOLD.
- IDLE: if any req bit set, pick winner round-robin starting at index ptr. Register grant, cs_n[winner]=0, and remaining count = req_len slice. A count of 0 is loaded as 1. Go to SETUP.
- SETUP: one cycle chip-select setup; go to ISSUE.
- ISSUE: eng_start=1, eng_data_in = tx_data slice of winner, tx_ack=1 (Moore decode, exactly one cycle); go to WAIT.
- WAIT: hold until eng_done. On eng_done: register rx_data=eng_data_out, pulse rx_valid next cycle, decrement count. If the decremented count is 0, go to HOLD; else go to ISSUE.
- HOLD: cs_n all high, txn_done=1, ptr = winner+1 (mod NREQ); go to IDLE; grant clears entering IDLE.
- Round-robin: ptr resets to 0. The priority search order is ptr, ptr+1, ..., wrapping at NREQ-1 to 0.
- Req deassertion after grant is ignored; the transaction runs to its latched count. req_len changes after grant are ignored.
- eng_done outside WAIT is ignored.
- There is no engine timeout; a missing eng_done holds WAIT indefinitely.
- Reset mid-transaction: all state to reset values immediately, cs_n all high, no txn_done.

## Timing
- Reset values:
  - cs_n all 1.
  - grant 0, tx_ack 0, eng_start 0, eng_data_in 0.
  - rx_data 0x00, rx_valid 0, txn_done 0, busy 0.
  - ptr 0, state IDLE.
- req seen in IDLE at cycle T gives grant and cs_n low at T+1 (SETUP), then eng_start and tx_ack at T+2.
- eng_done at cycle D:
  - rx_valid and rx_data at D+1.
  - If bytes remain, eng_start for the next byte also at D+1 (state ISSUE).
  - If no bytes remain, txn_done at D+1 (HOLD), cs_n high from D+1.
- Minimum cs_n high time between transactions is 2 cycles (HOLD + IDLE).
- One byte costs 2 + (eng_done latency) cycles.
- Simultaneous requests resolve in one IDLE cycle; a requester that lost arbitration keeps req high and wins within NREQ-1 transactions.

## Test plan
- Single requester 0, len 1, tx 0xA5, engine returns 0x3C after 18 cycles:
  - grant=0001 and cs_n=1110 at T+1; one eng_start with eng_data_in=0xA5.
  - rx_valid with 0x3C; txn_done one cycle later than rx_valid's eng_done edge, then cs_n=1111.
- Requester 2, len 3, bytes 0x11, 0x22, 0x33:
  - Three eng_start/tx_ack pulses in order and three rx_valid pulses.
  - cs_n[2] stays low continuously from first start to txn_done.
- All four req high from reset with len 1: grants in order 0, 1, 2, 3, then 0 again; never two grant bits set.
- req_len=0 on requester 1: exactly one byte transferred, txn_done asserted.
- Assert reset_n low during WAIT of a 3-byte transfer: cs_n=1111, grant=0, busy=0 immediately. After release, a new request starts cleanly from ptr 0.
- Requester 3 drops req after its grant with len 2 while requester 1 requests: requester 3 completes 2 bytes, then requester 1 is granted.
